// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, ALU and mux
// selects, and the main control FSM state type.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_AND   = 2'b11;

   localparam logic [1:0] ALUB_REG    = 2'b00;
   localparam logic [1:0] ALUB_FOUR   = 2'b01;
   localparam logic [1:0] ALUB_IMM    = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_RSEXEC = 4'd6,
      ST_RWB    = 4'd7,
      ST_IEXEC  = 4'd8,
      ST_IWB    = 4'd9,
      ST_BRANCH = 4'd10,
      ST_JUMP   = 4'd11,
      ST_TRAP   = 4'd12
   } state_t;

endpackage

// File: rtl/multicycle_control_perf_counters.sv
// Free-running cycle and retired-instruction counters; both wrap naturally.
module perf_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_cycle,
   input  logic             en_instr,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (en_cycle) cycle_cnt <= cycle_cnt + 1'b1;
         if (en_instr) instr_cnt <= instr_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath with memory wait states,
// illegal-opcode trap and performance counters.
//
//  state  | meaning
//  FETCH  | read instruction at PC, PC+4; wait for mem_ready
//  DECODE | read registers, precompute branch target
//  MEMADR | compute load/store address
//  MEMRD  | load data read; wait for mem_ready
//  MEMWB  | write MDR to rt
//  MEMWR  | store data write; wait for mem_ready
//  RSEXEC | R-type ALU operation
//  RWB    | write ALUOut to rd
//  IEXEC  | addi/andi ALU operation
//  IWB    | write ALUOut to rt
//  BRANCH | compare and conditionally load branch target
//  JUMP   | load jump target
//  TRAP   | illegal opcode; held until reset
module multicycle_control
   import mips_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_beq,
   output logic             pc_write_bne,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             trap,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   state_t state;
   state_t state_nxt;
   logic   en_cycle;
   logic   en_instr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = ST_FETCH;
      case (state)
         ST_FETCH:  state_nxt = mem_ready ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:     state_nxt = ST_MEMADR;
               OP_RTYPE:         state_nxt = ST_RSEXEC;
               OP_ADDI, OP_ANDI: state_nxt = ST_IEXEC;
               OP_BEQ, OP_BNE:   state_nxt = ST_BRANCH;
               OP_J:             state_nxt = ST_JUMP;
               default:          state_nxt = ST_TRAP;
            endcase
         end
         ST_MEMADR: state_nxt = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
         ST_MEMRD:  state_nxt = mem_ready ? ST_MEMWB : ST_MEMRD;
         ST_MEMWB:  state_nxt = ST_FETCH;
         ST_MEMWR:  state_nxt = mem_ready ? ST_FETCH : ST_MEMWR;
         ST_RSEXEC: state_nxt = ST_RWB;
         ST_RWB:    state_nxt = ST_FETCH;
         ST_IEXEC:  state_nxt = ST_IWB;
         ST_IWB:    state_nxt = ST_FETCH;
         ST_BRANCH: state_nxt = ST_FETCH;
         ST_JUMP:   state_nxt = ST_FETCH;
         ST_TRAP:   state_nxt = ST_TRAP;
         default:   state_nxt = ST_FETCH;
      endcase
   end

   always_comb begin
      pc_write     = 1'b0;
      pc_write_beq = 1'b0;
      pc_write_bne = 1'b0;
      i_or_d       = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      mem_to_reg   = 1'b0;
      reg_dst      = 1'b0;
      reg_write    = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = ALUB_REG;
      alu_op       = ALUOP_ADD;
      pc_source    = PCSRC_ALU;
      trap         = 1'b0;
      case (state)
         ST_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = ALUB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         ST_DECODE: alu_src_b = ALUB_IMM_SH;
         ST_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = ALUB_IMM;
         end
         ST_MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         ST_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         ST_MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         ST_RSEXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         ST_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         ST_IEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = ALUB_IMM;
            alu_op    = (opcode == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
         end
         ST_IWB: reg_write = 1'b1;
         ST_BRANCH: begin
            alu_src_a    = 1'b1;
            alu_op       = ALUOP_SUB;
            pc_source    = PCSRC_ALUOUT;
            pc_write_beq = (opcode == OP_BEQ);
            pc_write_bne = (opcode == OP_BNE);
         end
         ST_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         ST_TRAP: trap = 1'b1;
         default: ;
      endcase
   end

   // Retire on the exit edge of each instruction's final state.
   assign en_cycle = (state != ST_TRAP);
   assign en_instr = (state == ST_MEMWB) || (state == ST_RWB) || (state == ST_IWB) ||
                     (state == ST_BRANCH) || (state == ST_JUMP) ||
                     ((state == ST_MEMWR) && mem_ready);

   perf_counters #(
      .CNT_W (CNT_W)
   ) u_perf_counters (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_cycle  (en_cycle),
      .en_instr  (en_instr),
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle control words and
// counters compared against an instruction-level phase model.
module tb_multicycle_control;

   localparam int CW = 32;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_beq;
      logic       pc_write_bne;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       trap;
   } ctl_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [5:0]    opcode;
   logic          mem_ready;
   logic          pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read, mem_write;
   logic          ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, trap;
   logic [1:0]    alu_src_b, alu_op, pc_source;
   logic [CW-1:0] cycle_cnt, instr_cnt;
   ctl_t          got;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [CW-1:0] exp_cycles;
   logic [CW-1:0] exp_instr;

   multicycle_control #(.CNT_W(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .opcode       (opcode),
      .mem_ready    (mem_ready),
      .pc_write     (pc_write),
      .pc_write_beq (pc_write_beq),
      .pc_write_bne (pc_write_bne),
      .i_or_d       (i_or_d),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .ir_write     (ir_write),
      .mem_to_reg   (mem_to_reg),
      .reg_dst      (reg_dst),
      .reg_write    (reg_write),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .alu_op       (alu_op),
      .pc_source    (pc_source),
      .trap         (trap),
      .cycle_cnt    (cycle_cnt),
      .instr_cnt    (instr_cnt)
   );

   always #5 clk = ~clk;

   assign got = {pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read, mem_write,
                 ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                 alu_op, pc_source, trap};

   // Control word the datapath needs in each named phase of an instruction.
   function automatic ctl_t phase_word(string ph, logic rdy, logic [5:0] op);
      ctl_t w;
      w = '0;
      case (ph)
         "FETCH":  begin w.mem_read = 1; w.alu_src_b = 2'b01; w.ir_write = rdy; w.pc_write = rdy; end
         "DECODE": w.alu_src_b = 2'b11;
         "MEMADR": begin w.alu_src_a = 1; w.alu_src_b = 2'b10; end
         "MEMRD":  begin w.mem_read = 1; w.i_or_d = 1; end
         "MEMWB":  begin w.reg_write = 1; w.mem_to_reg = 1; end
         "MEMWR":  begin w.mem_write = 1; w.i_or_d = 1; end
         "RSEXEC": begin w.alu_src_a = 1; w.alu_op = 2'b10; end
         "RWB":    begin w.reg_write = 1; w.reg_dst = 1; end
         "IEXEC":  begin w.alu_src_a = 1; w.alu_src_b = 2'b10; w.alu_op = (op == 6'b001100) ? 2'b11 : 2'b00; end
         "IWB":    w.reg_write = 1;
         "BRANCH": begin
            w.alu_src_a = 1; w.alu_op = 2'b01; w.pc_source = 2'b01;
            w.pc_write_beq = (op == 6'b000100); w.pc_write_bne = (op == 6'b000101);
         end
         "JUMP":   begin w.pc_write = 1; w.pc_source = 2'b10; end
         "TRAP":   w.trap = 1;
         default:  w = '0;
      endcase
      return w;
   endfunction

   // Runs one instruction from its first FETCH cycle; wf/wm = not-ready cycles
   // in FETCH and in the memory-access phase. Illegal opcodes are watched for
   // 10 cycles in TRAP.
   task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
      string ph_q[$];
      bit    rdy_q[$];
      bit    legal;
      ctl_t  exp;
      legal = op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                         6'b000101, 6'b000010, 6'b001000, 6'b001100};
      n_checks++;
      if (cycle_cnt !== exp_cycles) begin
         n_fail++;
         $display("FAIL cycle_cnt op=%b got %0d expected %0d", op, cycle_cnt, exp_cycles);
      end
      n_checks++;
      if (instr_cnt !== exp_instr) begin
         n_fail++;
         $display("FAIL instr_cnt op=%b got %0d expected %0d", op, instr_cnt, exp_instr);
      end
      for (int i = 0; i < wf; i++) begin ph_q.push_back("FETCH"); rdy_q.push_back(1'b0); end
      ph_q.push_back("FETCH");  rdy_q.push_back(1'b1);
      ph_q.push_back("DECODE"); rdy_q.push_back(1'($urandom));
      case (op)
         6'b100011: begin
            ph_q.push_back("MEMADR"); rdy_q.push_back(1'($urandom));
            for (int i = 0; i < wm; i++) begin ph_q.push_back("MEMRD"); rdy_q.push_back(1'b0); end
            ph_q.push_back("MEMRD"); rdy_q.push_back(1'b1);
            ph_q.push_back("MEMWB"); rdy_q.push_back(1'($urandom));
         end
         6'b101011: begin
            ph_q.push_back("MEMADR"); rdy_q.push_back(1'($urandom));
            for (int i = 0; i < wm; i++) begin ph_q.push_back("MEMWR"); rdy_q.push_back(1'b0); end
            ph_q.push_back("MEMWR"); rdy_q.push_back(1'b1);
         end
         6'b000000: begin
            ph_q.push_back("RSEXEC"); rdy_q.push_back(1'($urandom));
            ph_q.push_back("RWB");    rdy_q.push_back(1'($urandom));
         end
         6'b001000, 6'b001100: begin
            ph_q.push_back("IEXEC"); rdy_q.push_back(1'($urandom));
            ph_q.push_back("IWB");   rdy_q.push_back(1'($urandom));
         end
         6'b000100, 6'b000101: begin ph_q.push_back("BRANCH"); rdy_q.push_back(1'($urandom)); end
         6'b000010: begin ph_q.push_back("JUMP"); rdy_q.push_back(1'($urandom)); end
         default: repeat (10) begin ph_q.push_back("TRAP"); rdy_q.push_back(1'($urandom)); end
      endcase
      for (int i = 0; i < ph_q.size(); i++) begin
         mem_ready = rdy_q[i];
         opcode    = (ph_q[i] == "FETCH") ? 6'($urandom) : op;
         @(negedge clk);
         exp = phase_word(ph_q[i], rdy_q[i], op);
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL ctl op=%b cycle=%0d phase=%s got %h expected %h",
                     op, i, ph_q[i], got, exp);
         end
         @(posedge clk);
         #1;
      end
      if (legal) begin
         exp_cycles = exp_cycles + CW'(ph_q.size());
         exp_instr  = exp_instr + 1'b1;
      end else begin
         exp_cycles = exp_cycles + CW'(2);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'b000000;
      #3;
      n_checks++;
      if (got !== phase_word("FETCH", 1'b0, 6'b0)) begin
         n_fail++; $display("FAIL reset_ctl got %h expected %h", got, phase_word("FETCH", 1'b0, 6'b0));
      end
      n_checks++;
      if (cycle_cnt !== '0 || instr_cnt !== '0 || trap !== 1'b0) begin
         n_fail++; $display("FAIL reset_state cycle=%0d instr=%0d trap=%b expected 0 0 0", cycle_cnt, instr_cnt, trap);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_cycles = '0; exp_instr = '0;
   endtask

   task automatic test_lw();
      run_instr(6'b100011, 0, 0);
   endtask

   task automatic test_sw_wait();
      run_instr(6'b101011, 0, 3);
   endtask

   task automatic test_branch();
      run_instr(6'b000100, 0, 0);
      run_instr(6'b000101, 0, 0);
      run_instr(6'b000010, 0, 0);
   endtask

   task automatic test_imm();
      run_instr(6'b001000, 0, 0);
      run_instr(6'b001100, 0, 0);
      run_instr(6'b000000, 0, 0);
   endtask

   task automatic test_fetch_wait();
      run_instr(6'b000000, 2, 0);
      run_instr(6'b100011, 1, 2);
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops [8];
      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
              6'b000101, 6'b000010, 6'b001000, 6'b001100};
      for (int n = 0; n < 60; n++)
         run_instr(ops[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 3));
   endtask

   task automatic test_trap();
      run_instr(6'b111111, 0, 0);
      n_checks++;
      if (cycle_cnt !== exp_cycles || instr_cnt !== exp_instr) begin
         n_fail++;
         $display("FAIL trap_frozen cycle=%0d instr=%0d expected %0d %0d", cycle_cnt, instr_cnt, exp_cycles, exp_instr);
      end
      mem_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (got !== phase_word("FETCH", 1'b0, 6'b0)) begin
         n_fail++; $display("FAIL trap_reset_ctl got %h expected %h", got, phase_word("FETCH", 1'b0, 6'b0));
      end
      n_checks++;
      if (trap !== 1'b0 || cycle_cnt !== '0 || instr_cnt !== '0) begin
         n_fail++; $display("FAIL trap_reset trap=%b cycle=%0d instr=%0d expected 0 0 0", trap, cycle_cnt, instr_cnt);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_cycles = '0; exp_instr = '0;
      run_instr(6'b100011, 0, 0);
      run_instr(6'b000010, 0, 0);
      run_instr(6'b000000, 0, 0);
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_wait();
      test_branch();
      test_imm();
      test_fetch_wait();
      test_back_to_back();
      test_trap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM that sequences the multi-cycle MIPS datapath: shared instruction/data memory, IR, A/B/ALUOut registers and a single ALU.
- Replaces the single-cycle combinational decoder.
- Adds a memory-ready wait handshake, an illegal-opcode trap, and cycle and retired-instruction counters for performance measurement.

Parameters:
- CNT_W, 32, width of the cycle_cnt and instr_cnt counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- mem_ready  in  1  memory has completed the current access; sampled in FETCH, MEMRD, MEMWR.
- pc_write  out  1  unconditional PC load.
- pc_write_beq  out  1  PC load if ALU zero.
- pc_write_bne  out  1  PC load if ALU not zero.
- i_or_d  out  1  0 = memory address from PC, 1 = from ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  load IR.
- mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  write register: 0 = rt, 1 = rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct, 11 = and.
- pc_source  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- trap  out  1  illegal opcode seen; sticky.
- cycle_cnt  out  CNT_W  clock cycles since reset.
- instr_cnt  out  CNT_W  instructions retired since reset.

Behaviour:
- Async reset: state=FETCH, trap=0, both counters=0.
- Outputs are decoded from state only, except the mem_ready gating listed below.
- Every strobe not listed for a state is 0; multi-bit selects not listed are 00.
- FETCH:
  - outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - transition: go to DECODE when mem_ready=1, else hold.
- DECODE:
  - outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target).
  - dispatch on opcode:
    - 100011 lw, 101011 sw -> MEMADR
    - 000000 R-type -> RSEXEC
    - 001000 addi -> IEXEC
    - 001100 andi -> IEXEC
    - 000100 beq, 000101 bne -> BRANCH
    - 000010 j -> JUMP
    - any other opcode -> TRAP
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Hold until mem_ready, then -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. -> FETCH.
- MEMWR: mem_write=1, i_or_d=1. Hold until mem_ready, then -> FETCH. mem_write stays asserted for every wait cycle.
- RSEXEC: alu_src_a=1, alu_src_b=00, alu_op=10. -> RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10. alu_op=00 for addi, 11 for andi; the opcode is held in IR. -> IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01. pc_write_beq=1 for beq, pc_write_bne=1 for bne. -> FETCH.
- JUMP: pc_write=1, pc_source=10. -> FETCH.
- TRAP: all strobes 0, trap=1. Absorbing; exited only by reset.
- Latency with mem_ready tied high: lw 5 cycles; sw, R-type, addi, andi 4; beq, bne, j 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- cycle_cnt: +1 every clock while not in TRAP. Frozen in TRAP. Wraps modulo 2^CNT_W.
- instr_cnt: +1 on the final-state exit of each instruction (MEMWB, MEMWR with mem_ready, RWB, IWB, BRANCH, JUMP). Wraps modulo 2^CNT_W. Never increments for a trapped opcode.
- Reset asserted mid-instruction: return to FETCH immediately (asynchronously). No partial write strobe may persist past reset assertion.
- State encoding is implementation choice. No unreachable state may be left unhandled: any unused encoding -> FETCH.

Decomposition:
- Shared package mips_pkg:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI.
  - ALUOp encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_AND.
  - ALU-B select and PC-source select encodings.
  - FSM state enum.
- One sub-module, perf_counters: holds cycle_cnt and instr_cnt. Inputs: clk, rst_n, en_cycle, en_instr.

Test Plan:
- Reset, then run lw with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write=1 and mem_to_reg=1 in cycle 5 only. instr_cnt=1, cycle_cnt=5.
- sw with mem_ready=0 for 3 cycles in MEMWR -> mem_write high for 4 consecutive cycles, then FETCH. instr_cnt increments once.
- beq then bne -> pc_write_beq=1 only in beq's cycle 3; pc_write_bne=1 only in bne's cycle 3. alu_op=01 in both. Each takes 3 cycles.
- addi then andi -> IEXEC alu_op=00 then 11, alu_src_b=10. IWB reg_dst=0. 4 cycles each.
- FETCH with mem_ready=0 for 2 cycles -> ir_write and pc_write stay 0 until the mem_ready cycle, then pulse for exactly 1 cycle.
- opcode 111111 -> TRAP, trap=1 and all strobes 0 for 10 cycles, counters frozen. Assert rst_n=0 mid-cycle -> FETCH, trap=0, counters 0 immediately.
